// File: rtl/ui_pkg.sv
// Shared UI definitions: event-type encodings and board-clock timing defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ui_pkg;

    // Event kind carried on the scheduler output.
    localparam logic EVT_PRESS  = 1'b0;
    localparam logic EVT_REPEAT = 1'b1;

    // Auto-repeat timing for the 100 MHz board clock: 50 ms to first repeat, then every 10 ms.
    localparam int          DEF_CNT_W         = 24;
    localparam logic [23:0] DEF_HOLD_CYCLES   = 24'd5_000_000;
    localparam logic [23:0] DEF_REPEAT_CYCLES = 24'd1_000_000;

endpackage

// File: rtl/key_event_scheduler_if.sv
// Key event stream: one event (key index + press/repeat kind) per valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: producer holds key/repeat stable while evt_valid=1 and evt_ready=0.
// Ports: evt_valid/evt_key/evt_repeat driven by master, evt_ready driven by slave.
interface key_event_scheduler_if #(
    parameter int KEY_W = 2
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_key;
    logic             evt_repeat;

    modport master (output evt_valid, output evt_key, output evt_repeat, input evt_ready);
    modport slave  (input evt_valid, input evt_key, input evt_repeat, output evt_ready);
endinterface

// File: rtl/key_hold_timer.sv
// Per-key edge detect, hold counter and press/repeat request bits.
// Latency: press request set on the edge that samples the rising key level.
// Backpressure: requests stay set until granted; a second press while pending pulses overrun_o.
// Ports: clk_i/rst_n_i, en_i (init done), key_i, grant_press_i/grant_rep_i in;
//        press_pend_o/rep_pend_o (requests), overrun_o (one-cycle lost-press pulse) out.
module key_hold_timer #(
    parameter int               CNT_W         = 24,
    parameter logic [CNT_W-1:0] HOLD_CYCLES   = 24'd5_000_000,
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = 24'd1_000_000,
    parameter bit               REPEAT_EN     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic key_i,
    input  logic grant_press_i,
    input  logic grant_rep_i,
    output logic press_pend_o,
    output logic rep_pend_o,
    output logic overrun_o
);
    // Counter value that fires a repeat on the next increment, and where it restarts so
    // that later repeats come REPEAT_CYCLES apart.
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_CYCLES - CNT_W'(1);
    localparam logic [CNT_W-1:0] RELOAD    = HOLD_CYCLES - REPEAT_CYCLES;

    logic             key_prev_q;
    logic             press_pend_q, press_pend_d;
    logic             rep_pend_q, rep_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_edge;
    logic             rep_fire;

    // en_i is low during the init cycle so a key held through reset raises no edge.
    assign press_edge = en_i & key_i & ~key_prev_q;

    always_comb begin
        // A new edge keeps the bit set even when the old request is granted this cycle.
        press_pend_d = press_edge | (press_pend_q & ~grant_press_i);
        overrun_o    = press_edge & press_pend_q & ~grant_press_i;

        rep_fire = 1'b0;
        cnt_d    = cnt_q;
        if (!en_i || press_edge || !key_i) begin
            cnt_d = '0;
        end else if (REPEAT_EN) begin
            if (cnt_q == HOLD_LAST) begin
                cnt_d    = RELOAD;
                rep_fire = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A repeat finding any request already queued is dropped without overrun.
        rep_pend_d = (rep_pend_q & ~grant_rep_i) | (rep_fire & ~press_pend_q & ~rep_pend_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            key_prev_q   <= 1'b0;
            press_pend_q <= 1'b0;
            rep_pend_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            key_prev_q   <= key_i;
            press_pend_q <= press_pend_d;
            rep_pend_q   <= rep_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press_pend_o = press_pend_q;
    assign rep_pend_o   = rep_pend_q;
endmodule

// File: rtl/key_event_scheduler.sv
// Serializes per-key press/auto-repeat requests onto one valid/ready event stream (round-robin).
// Latency: key rise sampled at edge t -> request at t, evt_valid at t+1 when output is free.
// Backpressure: output register holds while evt_ready=0; requests wait; lost presses set o_overrun.
// Ports: i_clk, i_rst_n, i_keys, i_clr_overrun in; o_overrun, o_pending out; evt (master) stream.
module key_event_scheduler
    import ui_pkg::*;
#(
    parameter int               N_KEYS        = 4,
    parameter int               KEY_W         = 2,
    parameter int               CNT_W         = DEF_CNT_W,
    parameter logic [CNT_W-1:0] HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit               REPEAT_EN     = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_KEYS-1:0]     i_keys,
    input  logic                  i_clr_overrun,
    output logic                  o_overrun,
    output logic [N_KEYS-1:0]     o_pending,
    key_event_scheduler_if.master evt
);
    logic              init_q;
    logic [N_KEYS-1:0] press_req, rep_req, req;
    logic [N_KEYS-1:0] grant_press, grant_rep, ovr_pulse;
    logic [KEY_W-1:0]  rr_q, rr_d;
    logic [KEY_W-1:0]  gnt_idx, cand;
    logic              gnt_found;
    logic              load;
    logic              vld_q, vld_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              rep_q, rep_d;
    logic              ovr_q, ovr_d;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_hold_timer #(
            .CNT_W        (CNT_W),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_EN)
        ) u_timer (
            .clk_i        (i_clk),
            .rst_n_i      (i_rst_n),
            .en_i         (init_q),
            .key_i        (i_keys[k]),
            .grant_press_i(grant_press[k]),
            .grant_rep_i  (grant_rep[k]),
            .press_pend_o (press_req[k]),
            .rep_pend_o   (rep_req[k]),
            .overrun_o    (ovr_pulse[k])
        );
    end

    assign req       = press_req | rep_req;
    assign o_pending = req;
    assign load      = (~vld_q | evt.evt_ready) & (|req);

    always_comb begin
        // Round-robin search: first requester at or above the pointer, wrapping.
        gnt_idx   = '0;
        gnt_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            cand = KEY_W'((int'(rr_q) + i) % N_KEYS);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end

        // Press wins over repeat within a key; only the granted kind is cleared.
        grant_press = '0;
        grant_rep   = '0;
        if (load) begin
            grant_press[gnt_idx] = press_req[gnt_idx];
            grant_rep[gnt_idx]   = ~press_req[gnt_idx] & rep_req[gnt_idx];
        end

        rr_d  = rr_q;
        vld_d = vld_q;
        key_d = key_q;
        rep_d = rep_q;
        if (load) begin
            vld_d = 1'b1;
            key_d = gnt_idx;
            rep_d = press_req[gnt_idx] ? EVT_PRESS : EVT_REPEAT;
            rr_d  = (gnt_idx == KEY_W'(N_KEYS - 1)) ? '0 : gnt_idx + KEY_W'(1);
        end else if (!vld_q || evt.evt_ready) begin
            vld_d = 1'b0;
        end

        // A lost press in the same cycle as a clear still leaves the flag set.
        ovr_d = (|ovr_pulse) | (ovr_q & ~i_clr_overrun);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_q <= 1'b0;
            rr_q   <= '0;
            vld_q  <= 1'b0;
            key_q  <= '0;
            rep_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            rr_q   <= rr_d;
            vld_q  <= vld_d;
            key_q  <= key_d;
            rep_q  <= rep_d;
            ovr_q  <= ovr_d;
        end
    end

    assign evt.evt_valid  = vld_q;
    assign evt.evt_key    = key_q;
    assign evt.evt_repeat = rep_q;
    assign o_overrun      = ovr_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: ready driven by the bench, stalled and random.
module tb_key_event_scheduler;
    localparam int N      = 4;
    localparam int KW     = 2;
    localparam int CW     = 8;
    localparam int HOLD   = 16;
    localparam int REP    = 4;
    localparam bit REP_EN = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  keys;
    logic          clr;
    logic          overrun;
    logic [N-1:0]  pending;

    key_event_scheduler_if #(.KEY_W(KW)) ev ();

    key_event_scheduler #(
        .N_KEYS(N), .KEY_W(KW), .CNT_W(CW),
        .HOLD_CYCLES(8'd16), .REPEAT_CYCLES(8'd4), .REPEAT_EN(REP_EN)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_keys(keys), .i_clr_overrun(clr),
        .o_overrun(overrun), .o_pending(pending), .evt(ev)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued requests per key, cycles held since the press, output slot, pointer.
    bit          m_init;
    bit          m_prev [N];
    bit          m_pp   [N];
    bit          m_rp   [N];
    int          m_held [N];
    int          m_ptr;
    bit          m_vld, m_rep, m_ovr;
    logic [KW-1:0] m_key;

    int acc_key [$];
    bit acc_rep [$];

    wire [8:0] obs = {ev.evt_valid, ev.evt_key, ev.evt_repeat, pending, overrun};

    function automatic logic [8:0] exp_obs();
        logic [N-1:0] p;
        for (int k = 0; k < N; k++) p[k] = m_pp[k] | m_rp[k];
        return {m_vld, m_key, m_rep, p, m_ovr};
    endfunction

    task automatic model_reset();
        m_init = 0; m_ptr = 0; m_vld = 0; m_rep = 0; m_ovr = 0; m_key = '0;
        for (int k = 0; k < N; k++) begin
            m_prev[k] = 0; m_pp[k] = 0; m_rp[k] = 0; m_held[k] = 0;
        end
    endtask

    // Advance one clock: log handshakes seen by the consumer, step the model, sample after the edge.
    task automatic tick();
        bit any, load, ovr_set, gp, gr, edg, fire;
        int g, c, nh;
        bit n_pp [N];
        bit n_rp [N];
        if (ev.evt_valid && ev.evt_ready) begin
            acc_key.push_back(int'(ev.evt_key));
            acc_rep.push_back(ev.evt_repeat);
        end
        any = 0;
        for (int k = 0; k < N; k++) any |= m_pp[k] | m_rp[k];
        load = (!m_vld || ev.evt_ready) && any;
        g = -1;
        if (load)
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (g < 0 && (m_pp[c] || m_rp[c])) g = c;
            end
        ovr_set = 0;
        for (int k = 0; k < N; k++) begin
            gp  = load && g == k && m_pp[k];
            gr  = load && g == k && !m_pp[k] && m_rp[k];
            edg = m_init && keys[k] && !m_prev[k];
            ovr_set |= edg && m_pp[k] && !gp;
            n_pp[k] = edg || (m_pp[k] && !gp);
            nh = (!m_init || !keys[k] || edg) ? 0 : m_held[k] + 1;
            fire = REP_EN && nh >= HOLD && ((nh - HOLD) % REP) == 0;
            n_rp[k] = (m_rp[k] && !gr) || (fire && !m_pp[k] && !m_rp[k]);
            m_held[k] = nh;
        end
        @(posedge clk);
        #1;
        if (load) begin
            m_vld = 1; m_key = KW'(g); m_rep = !m_pp[g]; m_ptr = (g + 1) % N;
        end else if (!m_vld || ev.evt_ready) begin
            m_vld = 0;
        end
        for (int k = 0; k < N; k++) begin
            m_pp[k] = n_pp[k]; m_rp[k] = n_rp[k]; m_prev[k] = keys[k];
        end
        m_ovr = ovr_set || (m_ovr && !clr);
        m_init = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; keys = 4'b0010; clr = 0; ev.evt_ready = 1;
        model_reset();
        #12;
        checks++;
        if (obs !== 9'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 9'b0);
        end
        @(negedge clk) rst_n = 1;
        repeat (5) begin
            tick();
            checks++;
            if (ev.evt_valid !== 1'b0 || pending !== 4'b0000 || obs !== exp_obs()) begin
                errors++; $display("FAIL held_through_reset: got %b expected %b (no event)", obs, exp_obs());
            end
        end
        keys = 4'b0000;
        repeat (2) tick();
    endtask

    task automatic test_press_latency();
        ev.evt_ready = 1; keys = 4'b0100;
        tick();
        checks++;
        if (ev.evt_valid !== 1'b0 || pending !== 4'b0100) begin
            errors++; $display("FAIL latency_edge1: got vld=%b pend=%b expected vld=0 pend=0100", ev.evt_valid, pending);
        end
        tick();
        checks++;
        if (ev.evt_valid !== 1'b1 || ev.evt_key !== 2'd2 || ev.evt_repeat !== 1'b0 || pending !== 4'b0000) begin
            errors++; $display("FAIL latency_edge2: got vld=%b key=%0d rep=%b pend=%b expected 1 2 0 0000",
                               ev.evt_valid, ev.evt_key, ev.evt_repeat, pending);
        end
        tick();
        checks++;
        if (ev.evt_valid !== 1'b0 || obs !== exp_obs()) begin
            errors++; $display("FAIL latency_one_cycle: got %b expected %b", obs, exp_obs());
        end
        keys = 4'b0000;
        tick();
    endtask

    // Pointer sits at 3 after key 2 was granted, so the order is 3, 0, 1.
    task automatic test_rr_order();
        int exp_order [3] = '{3, 0, 1};
        acc_key.delete(); acc_rep.delete();
        ev.evt_ready = 0; keys = 4'b1011;
        repeat (4) begin
            tick();
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL rr_stall: got %b expected %b", obs, exp_obs());
            end
        end
        checks++;
        if (ev.evt_key !== 2'd3 || pending !== 4'b0011) begin
            errors++; $display("FAIL rr_first: got key=%0d pend=%b expected key=3 pend=0011", ev.evt_key, pending);
        end
        ev.evt_ready = 1; keys = 4'b0000;
        repeat (4) begin
            tick();
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL rr_drain: got %b expected %b", obs, exp_obs());
            end
        end
        checks++;
        if (acc_key.size() != 3) begin
            errors++; $display("FAIL rr_count: got %0d expected 3", acc_key.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_key[i] != exp_order[i]) begin
                    errors++; $display("FAIL rr_order[%0d]: got key %0d expected %0d", i, acc_key[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_repeat();
        int n_press, n_rep;
        acc_key.delete(); acc_rep.delete();
        ev.evt_ready = 1; keys = 4'b0010;
        repeat (38) begin
            tick();
            if (m_held[1] == 29) keys = 4'b0000;
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL repeat_cycle: got %b expected %b", obs, exp_obs());
            end
        end
        n_press = 0; n_rep = 0;
        foreach (acc_key[i]) begin
            if (acc_key[i] == 1 && !acc_rep[i]) n_press++;
            if (acc_key[i] == 1 && acc_rep[i]) n_rep++;
        end
        checks++;
        if (n_press != 1 || n_rep != 4) begin
            errors++; $display("FAIL repeat_count: got press=%0d repeat=%0d expected 1 and 4", n_press, n_rep);
        end
    endtask

    task automatic test_overrun();
        int n0;
        acc_key.delete(); acc_rep.delete();
        ev.evt_ready = 0;
        keys = 4'b1000; tick(); tick();
        keys = 4'b1001; tick();
        keys = 4'b1000; tick();
        keys = 4'b1001; clr = 1; tick();
        checks++;
        if (overrun !== 1'b1 || obs !== exp_obs()) begin
            errors++; $display("FAIL overrun_set_wins: got ovr=%b expected 1", overrun);
        end
        tick();
        checks++;
        if (overrun !== 1'b0 || obs !== exp_obs()) begin
            errors++; $display("FAIL overrun_clear: got ovr=%b expected 0", overrun);
        end
        clr = 0; ev.evt_ready = 1; keys = 4'b0000;
        repeat (5) tick();
        n0 = 0;
        foreach (acc_key[i]) if (acc_key[i] == 0) n0++;
        checks++;
        if (n0 != 1 || acc_key.size() != 2) begin
            errors++; $display("FAIL overrun_delivered: got key0=%0d total=%0d expected 1 and 2", n0, acc_key.size());
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 19) == 0) keys[k] = ~keys[k];
            ev.evt_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL random@%0d: got %b expected %b", cyc, obs, exp_obs());
            end
        end
        keys = 4'b0000; ev.evt_ready = 1; clr = 1;
        repeat (8) tick();
        clr = 0;
    endtask

    task automatic test_stall_reset();
        ev.evt_ready = 0; keys = 4'b0010;
        tick(); tick();
        repeat (10) begin
            tick();
            checks++;
            if (ev.evt_valid !== 1'b1 || ev.evt_key !== 2'd1 || ev.evt_repeat !== 1'b0 || obs !== exp_obs()) begin
                errors++; $display("FAIL stall_hold: got vld=%b key=%0d rep=%b expected 1 1 0",
                                   ev.evt_valid, ev.evt_key, ev.evt_repeat);
            end
        end
        #3 rst_n = 0;
        #1 model_reset();
        checks++;
        if (obs !== 9'b0) begin
            errors++; $display("FAIL async_reset: got %b expected %b", obs, 9'b0);
        end
        @(negedge clk) rst_n = 1;
        repeat (4) begin
            tick();
            checks++;
            if (ev.evt_valid !== 1'b0 || obs !== exp_obs()) begin
                errors++; $display("FAIL reset_reinit: got %b expected %b", obs, exp_obs());
            end
        end
        keys = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_rr_order();
        test_repeat();
        test_overrun();
        test_random();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
